// File: rtl/disparity_pkg.sv
// Shared state codes, SAD window constants and width helpers for the disparity block matcher.
package disparity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_SEPARATE = 3'd2,
    ST_SAD      = 3'd3,
    ST_FINALIZE = 3'd4
  } state_t;

  localparam int SAD_WIN = 5;
  localparam int SAD_W   = 11;
  localparam int COORD_W = 10;

  // Index width for n entries, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disparity_result_ram.sv
// Per-pixel disparity store: one write port and one registered read port (old data on collision).
module disparity_result_ram #(
  parameter int DEPTH = 30750,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/disparity.sv
// Row-wise 1x5 SAD stereo matcher writing per-pixel disparity into an internal result RAM.
// Optional reject of weak matches is enabled with the DISPARITY_SAD_THRESH_EN macro.
module disparity
  import disparity_pkg::*;
#(
  parameter int WIDTH      = 250,
  parameter int HEIGHT     = 125,
  parameter int MAXDISP    = 16,
  parameter int DISP_SCALE = 16
`ifdef DISPARITY_SAD_THRESH_EN
  ,
  parameter int SAD_THRESH = 600
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         image_data,
  input  logic               buffer_ready,
  input  logic [COORD_W-1:0] disp_href,
  input  logic [COORD_W-1:0] disp_vref,
  output logic [7:0]         new_image,
  output logic [COORD_W-1:0] buffer_href,
  output logic [COORD_W-1:0] buffer_vref,
  output logic               image_sel,
  output logic               idle,
  output logic [2:0]         state_LED
);

  localparam int RES_W = WIDTH - 4;
  localparam int DEPTH = RES_W * HEIGHT;
  localparam int AW    = bits_for(DEPTH);
  localparam int IW    = bits_for(WIDTH);
  localparam int DW    = bits_for(MAXDISP);
  localparam int FW    = bits_for(2 * WIDTH + 1);
  localparam int KW    = 3;

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] buffer_href_reg, buffer_vref_reg, c_reg, r_reg;
  logic               image_sel_reg;
  logic [FW-1:0]      fetch_cnt_reg;
  logic [DW-1:0]      d_reg, best_d_reg;
  logic [KW-1:0]      k_reg;
  logic [SAD_W-1:0]   acc_reg, best_sad_reg;
  logic               rd_valid_reg;

  logic fetch_done, capture_en, last_col, last_row, last_term, last_disp;
  assign fetch_done = (fetch_cnt_reg == FW'(2 * WIDTH));
  assign capture_en = (state_reg == ST_READ) && !fetch_done && buffer_ready;
  assign last_col   = (c_reg == COORD_W'(RES_W - 1));
  assign last_row   = (r_reg == COORD_W'(HEIGHT - 1));
  assign last_term  = (k_reg == KW'(SAD_WIN - 1));
  assign last_disp  = (d_reg == DW'(MAXDISP - 1));

  // One register pair per column so every column loads on its own address match.
  logic [7:0] left_row  [WIDTH];
  logic [7:0] right_row [WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
    logic [7:0] left_q, right_q;
    always_ff @(posedge clk) begin
      if (capture_en && buffer_href_reg == COORD_W'(gi)) begin
        if (image_sel_reg) begin
          right_q <= image_data;
        end else begin
          left_q <= image_data;
        end
      end
    end
    assign left_row[gi]  = left_q;
    assign right_row[gi] = right_q;
  end

  // Candidate is invalid while the right-image window would start left of column 0.
  logic             cand_valid;
  logic [IW-1:0]    l_idx, r_idx;
  logic [7:0]       l_pix, r_pix, abs_diff;
  logic [SAD_W-1:0] sad_sum;

  assign cand_valid = (c_reg >= COORD_W'(d_reg));
  assign l_idx      = IW'(c_reg) + IW'(k_reg);
  assign r_idx      = cand_valid ? (IW'(c_reg) + IW'(k_reg) - IW'(d_reg)) : '0;
  assign l_pix      = left_row[l_idx];
  assign r_pix      = right_row[r_idx];
  assign abs_diff   = (l_pix >= r_pix) ? (l_pix - r_pix) : (r_pix - l_pix);
  assign sad_sum    = ((k_reg == '0) ? '0 : acc_reg) + SAD_W'(abs_diff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (enable) state_next = ST_READ;
      ST_READ:     if (fetch_done) state_next = ST_SEPARATE;
      ST_SEPARATE: state_next = ST_SAD;
      ST_SAD:      if (last_term && last_disp) state_next = ST_FINALIZE;
      ST_FINALIZE: begin
        if (!last_col) begin
          state_next = ST_SEPARATE;
        end else if (!last_row) begin
          state_next = ST_READ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer_href_reg <= '0;
      buffer_vref_reg <= '0;
      image_sel_reg   <= 1'b0;
      fetch_cnt_reg   <= '0;
      c_reg           <= '0;
      r_reg           <= '0;
      d_reg           <= '0;
      k_reg           <= '0;
      acc_reg         <= '0;
      best_sad_reg    <= '1;
      best_d_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            r_reg           <= '0;
            buffer_vref_reg <= '0;
            buffer_href_reg <= '0;
            image_sel_reg   <= 1'b0;
            fetch_cnt_reg   <= '0;
          end
        end
        ST_READ: begin
          if (capture_en) begin
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
            if (buffer_href_reg == COORD_W'(WIDTH - 1)) begin
              buffer_href_reg <= '0;
              image_sel_reg   <= ~image_sel_reg;
            end else begin
              buffer_href_reg <= buffer_href_reg + 1'b1;
            end
          end
          if (fetch_done) begin
            c_reg <= '0;
          end
        end
        ST_SEPARATE: begin
          d_reg        <= '0;
          k_reg        <= '0;
          best_sad_reg <= '1;
          best_d_reg   <= '0;
        end
        ST_SAD: begin
          acc_reg <= sad_sum;
          if (last_term) begin
            k_reg <= '0;
            d_reg <= d_reg + 1'b1;
            // Strict compare keeps the smallest disparity on ties.
            if (cand_valid && sad_sum < best_sad_reg) begin
              best_sad_reg <= sad_sum;
              best_d_reg   <= d_reg;
            end
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        ST_FINALIZE: begin
          if (!last_col) begin
            c_reg <= c_reg + 1'b1;
          end else if (!last_row) begin
            r_reg           <= r_reg + 1'b1;
            buffer_vref_reg <= r_reg + 1'b1;
            buffer_href_reg <= '0;
            image_sel_reg   <= 1'b0;
            fetch_cnt_reg   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [15:0]   scaled;
  logic [7:0]    sat_pix, wr_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    ram_q;
  logic          rd_in_range;

  assign scaled  = 16'(best_d_reg) * 16'(DISP_SCALE);
  assign sat_pix = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
`ifdef DISPARITY_SAD_THRESH_EN
  assign wr_data = (best_sad_reg > SAD_W'(SAD_THRESH)) ? 8'h00 : sat_pix;
`else
  assign wr_data = sat_pix;
`endif

  assign wr_addr     = AW'(r_reg) * AW'(RES_W) + AW'(c_reg);
  assign rd_addr     = AW'(disp_vref) * AW'(RES_W) + AW'(disp_href);
  assign rd_in_range = (disp_href < COORD_W'(RES_W)) && (disp_vref < COORD_W'(HEIGHT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_in_range;
    end
  end

  disparity_result_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_result_ram (
    .clk     (clk),
    .we      (state_reg == ST_FINALIZE),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign new_image   = rd_valid_reg ? ram_q : 8'h00;
  assign buffer_href = buffer_href_reg;
  assign buffer_vref = buffer_vref_reg;
  assign image_sel   = image_sel_reg;
  assign idle        = (state_reg == ST_IDLE);
  assign state_LED   = state_reg;

endmodule

// File: tb/tb_disparity.sv
// Bench for disparity: frame-buffer model, SAD reference model, scoreboarded result reads.
module tb_disparity;

  localparam int W     = 16;
  localparam int H     = 4;
  localparam int MAXD  = 8;
  localparam int SCALE = 16;
  localparam int RW    = W - 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] image_data;
  logic       buffer_ready = 1'b1;
  logic [9:0] disp_href = '0;
  logic [9:0] disp_vref = '0;
  logic [7:0] new_image;
  logic [9:0] buffer_href, buffer_vref;
  logic       image_sel, idle;
  logic [2:0] state_LED;

  always #5 clk = ~clk;

  disparity #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .MAXDISP    (MAXD),
    .DISP_SCALE (SCALE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .image_data   (image_data),
    .buffer_ready (buffer_ready),
    .disp_href    (disp_href),
    .disp_vref    (disp_vref),
    .new_image    (new_image),
    .buffer_href  (buffer_href),
    .buffer_vref  (buffer_vref),
    .image_sel    (image_sel),
    .idle         (idle),
    .state_LED    (state_LED)
  );

  logic [7:0] left_img  [H][W];
  logic [7:0] right_img [H][W];
  logic       corrupt = 1'b0;

  always_comb begin
    image_data = 8'h00;
    if (corrupt) begin
      image_data = 8'hA5;
    end else if (buffer_href < 10'(W) && buffer_vref < 10'(H)) begin
      image_data = image_sel ? right_img[buffer_vref[1:0]][buffer_href[3:0]]
                             : left_img[buffer_vref[1:0]][buffer_href[3:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_images(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        if (mode == 0) begin
          left_img[r][x]  = 8'h40;
          right_img[r][x] = 8'h40;
        end else begin
          left_img[r][x]  = 8'(7 * x + r);
          right_img[r][x] = 8'(7 * (x + 3) + r);
        end
      end
    end
  endtask

  // Reference search: smallest d with strictly minimal SAD among valid candidates.
  function automatic logic [7:0] exp_pix(input int row, input int c);
    int best = 1 << 30;
    int bd = 0;
    for (int d = 0; d < MAXD; d++) begin
      if (c >= d) begin
        int s = 0;
        for (int k = 0; k < 5; k++) begin
          int lv = int'(left_img[row][c + k]);
          int rv = int'(right_img[row][c + k - d]);
          s += (lv > rv) ? lv - rv : rv - lv;
        end
        if (s < best) begin
          best = s;
          bd = d;
        end
      end
    end
    return (bd * SCALE > 255) ? 8'd255 : 8'(bd * SCALE);
  endfunction

  typedef struct {
    logic [9:0] href;
    logic [9:0] vref;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t sb_q[$];

  task automatic read_one(input logic [9:0] h, input logic [9:0] v, input logic [7:0] e,
                          input string name);
    rd_vec_t item;
    @(negedge clk);
    disp_href = h;
    disp_vref = v;
    sb_q.push_back('{h, v, e});
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    $display("read %s h=%0d v=%0d got=%0d exp=%0d", name, item.href, item.vref, new_image, item.exp);
    check(name, int'(new_image), int'(item.exp));
  endtask

  task automatic sweep(input string name);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < RW; c++) begin
        read_one(10'(c), 10'(r), exp_pix(r, c), name);
      end
    end
  endtask

  task automatic pulse_enable();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 5000) begin
      @(negedge clk);
      n++;
    end
    $display("frame %s done after %0d cycles", name, n);
    check({name, "_done"}, int'(idle), 1);
  endtask

  logic [2:0] seq[$];
  logic [2:0] mon_last = 3'd0;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && state_LED != mon_last) begin
      seq.push_back(state_LED);
      mon_last = state_LED;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t tbl[9];
    logic [9:0] h0, v0;
    logic       s0;
    int n;
    int ones, zeros;
    logic [2:0] exp_head[5];

    tbl[0] = '{10'd3,    10'd0,    8'd48};
    tbl[1] = '{10'd11,   10'd3,    8'd48};
    tbl[2] = '{10'd5,    10'd2,    8'd48};
    tbl[3] = '{10'd0,    10'd0,    8'd0};
    tbl[4] = '{10'd1,    10'd1,    8'd16};
    tbl[5] = '{10'd2,    10'd3,    8'd32};
    tbl[6] = '{10'd12,   10'd0,    8'd0};
    tbl[7] = '{10'd0,    10'd4,    8'd0};
    tbl[8] = '{10'd1023, 10'd1023, 8'd0};
    exp_head = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2};

    set_images(0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state with no enable.
    check("rst_idle", int'(idle), 1);
    check("rst_state", int'(state_LED), 0);
    check("rst_href", int'(buffer_href), 0);
    check("rst_vref", int'(buffer_vref), 0);
    check("rst_sel", int'(image_sel), 0);
    check("rst_new_image", int'(new_image), 0);

    // Flat images: every candidate ties, so d=0 everywhere.
    pulse_enable();
    wait_idle("flat");
    sweep("flat");

    // Shifted ramp: d=3 is the unique zero-SAD match.
    set_images(1);
    pulse_enable();
    wait_idle("ramp");
    sweep("ramp");
    for (int i = 0; i < 9; i++) begin
      read_one(tbl[i].href, tbl[i].vref, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Fetch stall mid-READ with garbage on the data bus.
    set_images(0);
    pulse_enable();
    wait_idle("reflat");
    set_images(1);
    pulse_enable();
    repeat (10) @(negedge clk);
    buffer_ready = 1'b0;
    corrupt = 1'b1;
    h0 = buffer_href;
    v0 = buffer_vref;
    s0 = image_sel;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_hold", int'({state_LED, buffer_href, buffer_vref, image_sel}),
            int'({3'd1, h0, v0, s0}));
    end
    buffer_ready = 1'b1;
    corrupt = 1'b0;
    wait_idle("stall");
    sweep("stall");

    // Enable pulsed during SAD must not disturb the run.
    seq.delete();
    mon_last = 3'd0;
    mon_en = 1'b1;
    pulse_enable();
    n = 0;
    while (state_LED != 3'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    pulse_enable();
    wait_idle("enable_ignored");
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    $display("state sequence length %0d", seq.size());
    check("seq_len", seq.size(), 4 * (1 + 3 * RW) + 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("seq_head%0d", i), (i < seq.size()) ? int'(seq[i]) : -1, int'(exp_head[i]));
    end
    ones = 0;
    zeros = 0;
    foreach (seq[i]) begin
      if (seq[i] == 3'd1) ones++;
      if (seq[i] == 3'd0) zeros++;
    end
    check("seq_reads", ones, H);
    check("seq_idles", zeros, 1);
    check("seq_last", (seq.size() > 0) ? int'(seq[seq.size() - 1]) : -1, 0);

    // Asynchronous reset during SAD of row 1, then a clean rerun.
    set_images(0);
    pulse_enable();
    wait_idle("preflat");
    set_images(1);
    pulse_enable();
    n = 0;
    while (!(state_LED == 3'd3 && buffer_vref == 10'd1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_row1_sad", int'(state_LED == 3'd3 && buffer_vref == 10'd1), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_idle", int'(idle), 1);
    check("async_state", int'(state_LED), 0);
    check("async_vref", int'(buffer_vref), 0);
    check("async_new_image", int'(new_image), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", int'(idle), 1);
    pulse_enable();
    wait_idle("rerun");
    sweep("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
